// File: rtl/io_key_debounce.sv
// -----------------------------------------------------------------------------
// io_key_debounce
//
// Multi-channel conditioner for board push-buttons and slide switches. Each
// channel has a flop synchroniser, polarity correction, a four-state debounce
// FSM, one-cycle rise/fall pulses and a sticky press flag with
// write-1-to-clear. A summary interrupt ORs all sticky flags.
//
// Optional feature macro: IO_KEY_REPEAT_EN
//   Defined   : while a channel stays pressed, extra o_rise pulses are produced
//               REPEAT_DELAY cycles after acceptance, then every REPEAT_PERIOD.
//   Undefined : exactly one o_rise pulse per press; REPEAT_* are ignored.
//
// Handshake note: there is no valid/ready flow here. Outputs are registered
// and valid every cycle after reset; i_evt_clr is a level strobe sampled at
// every rising edge (1 = clear that channel's sticky flag).
//
// Ports
//   i_clk       : system clock, rising edge
//   i_rst       : synchronous active-high reset
//   i_raw       : asynchronous raw pad inputs, one per channel
//   i_evt_clr   : write-1-to-clear strobe for o_evt
//   o_level     : debounced level, 1 = pressed/on (polarity corrected)
//   o_rise      : one-cycle pulse on accepted press (and auto-repeat)
//   o_fall      : one-cycle pulse on accepted release
//   o_evt       : sticky press flag per channel
//   o_irq       : OR of all o_evt bits (combinational)
//   o_dbg_state : per-channel FSM state, 2 bits per channel, channel i at [2i+:2]
// -----------------------------------------------------------------------------
module io_key_debounce #(
    parameter int CH            = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [CH-1:0]   i_raw,
    input  logic [CH-1:0]   i_evt_clr,
    output logic [CH-1:0]   o_level,
    output logic [CH-1:0]   o_rise,
    output logic [CH-1:0]   o_fall,
    output logic [CH-1:0]   o_evt,
    output logic            o_irq,
    output logic [2*CH-1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        REL   = 2'd0,
        CHK_P = 2'd1,
        PRS   = 2'd2,
        CHK_R = 2'd3
    } state_t;

    localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // Raw value of an idle (released) pad; also the polarity-correction mask.
    localparam logic [CH-1:0]  IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [CH-1:0] sync_q [SYNC_STAGES];
    logic [CH-1:0] s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= IDLE_RAW;
            end
        end else begin
            sync_q[0] <= i_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;

    // ------------------------------------------------------------------
    // Debounce FSM state and outputs
    // ------------------------------------------------------------------
    state_t           state_q [CH];
    state_t           state_d [CH];
    logic [CNT_W-1:0] cnt_q   [CH];
    logic [CNT_W-1:0] cnt_d   [CH];
    logic [CH-1:0]    level_q, level_d;
    logic [CH-1:0]    rise_q,  rise_d;
    logic [CH-1:0]    fall_q,  fall_d;
    logic [CH-1:0]    evt_q,   evt_d;
    logic [CH-1:0]    rpt_pulse;

`ifdef IO_KEY_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat hold counter: counts cycles spent in PRS. rpt_q marks that
    // the initial delay has elapsed so the period applies from then on.
    // ------------------------------------------------------------------
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_DLY = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_PER = HOLD_W'(REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_q [CH];
    logic [HOLD_W-1:0] hold_d [CH];
    logic [CH-1:0]     rpt_q, rpt_d;

    always_comb begin
        rpt_pulse = '0;
        rpt_d     = rpt_q;
        for (int i = 0; i < CH; i++) begin
            hold_d[i] = hold_q[i];
            if (state_q[i] == PRS && s[i]) begin
                if ((hold_q[i] + HOLD_ONE) == (rpt_q[i] ? HOLD_PER : HOLD_DLY)) begin
                    rpt_pulse[i] = 1'b1;
                    rpt_d[i]     = 1'b1;
                    hold_d[i]    = '0;
                end else begin
                    hold_d[i] = hold_q[i] + HOLD_ONE;
                end
            end else begin
                // Not holding in PRS (including the edge that leaves it):
                // the next press starts from a fresh delay.
                hold_d[i] = '0;
                rpt_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rpt_q <= '0;
            for (int i = 0; i < CH; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            rpt_q <= rpt_d;
            for (int i = 0; i < CH; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end
`else
    assign rpt_pulse = '0;
`endif

    // Next-state logic for every channel.
    always_comb begin
        level_d = level_q;
        rise_d  = rpt_pulse;
        fall_d  = '0;
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                REL: begin
                    if (s[i]) begin
                        state_d[i] = CHK_P;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                CHK_P: begin
                    if (!s[i]) begin
                        state_d[i] = REL;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = PRS;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                PRS: begin
                    if (!s[i]) begin
                        state_d[i] = CHK_R;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                CHK_R: begin
                    if (s[i]) begin
                        state_d[i] = PRS;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = REL;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = REL;
                    cnt_d[i]   = '0;
                end
            endcase
        end
        // Set wins over clear: a clear that coincides with a press pulse,
        // whether at the edge producing it or while it is visible, is ignored.
        evt_d = (evt_q & ~(i_evt_clr & ~rise_q)) | rise_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            evt_q   <= '0;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= REL;
                cnt_q[i]   <= '0;
            end
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        o_dbg_state = '0;
        for (int i = 0; i < CH; i++) begin
            o_dbg_state[2*i +: 2] = state_q[i];
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_evt   = evt_q;
    assign o_irq   = |evt_q;

endmodule

// File: tb/tb_io_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_io_key_debounce
//
// Directed scenarios followed by randomized key activity. A behavioural model
// tracks, per channel, how many consecutive synchronised samples disagree with
// the accepted level; an expected output word is queued for every clock edge
// and a separate monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_io_key_debounce;

    localparam int CH     = 4;
    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int DLY    = 20;
    localparam int PER    = 5;
    localparam int W      = 4 * CH + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [CH-1:0]   raw;
    logic [CH-1:0]   evt_clr;
    logic [CH-1:0]   level, rise, fall, evt;
    logic            irq;
    logic [2*CH-1:0] dbg_state;

    io_key_debounce #(
        .CH            (CH),
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .ACTIVE_LOW    (1),
        .REPEAT_DELAY  (DLY),
        .REPEAT_PERIOD (PER)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_raw       (raw),
        .i_evt_clr   (evt_clr),
        .o_level     (level),
        .o_rise      (rise),
        .o_fall      (fall),
        .o_evt       (evt),
        .o_irq       (irq),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0]  exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    int            mon_cycle = 0;

    // ---------------- reference model ----------------
    logic [CH-1:0] hist_q[$];      // raw samples in flight through the synchroniser
    int            run  [CH];      // consecutive samples disagreeing with level
    int            held [CH];      // cycles held pressed since acceptance
    logic [CH-1:0] m_lvl, m_rise, m_fall, m_evt;

    task automatic model_edge(input logic [CH-1:0] r, input logic [CH-1:0] clr, input logic rs);
        logic [CH-1:0] sv;
        logic [CH-1:0] rs_v;
        logic [CH-1:0] fl_v;
        if (rs) begin
            hist_q.delete();
            repeat (SYNC) hist_q.push_back('1);
            m_lvl  = '0;
            m_rise = '0;
            m_fall = '0;
            m_evt  = '0;
            for (int c = 0; c < CH; c++) begin
                run[c]  = 0;
                held[c] = 0;
            end
        end else begin
            sv = ~hist_q.pop_front();  // pressed when pad is low
            hist_q.push_back(r);
            rs_v = '0;
            fl_v = '0;
            for (int c = 0; c < CH; c++) begin
                if (sv[c] != m_lvl[c]) begin
                    held[c] = 0;
                    run[c]  = run[c] + 1;
                    if (run[c] == STABLE + 1) begin
                        m_lvl[c] = sv[c];
                        run[c]   = 0;
                        if (sv[c]) rs_v[c] = 1'b1;
                        else       fl_v[c] = 1'b1;
                    end
                end else if (run[c] != 0) begin
                    run[c]  = 0;
                    held[c] = 0;
                end else if (m_lvl[c]) begin
`ifdef IO_KEY_REPEAT_EN
                    held[c] = held[c] + 1;
                    if (held[c] == DLY || (held[c] > DLY && ((held[c] - DLY) % PER) == 0))
                        rs_v[c] = 1'b1;
`endif
                end
            end
            m_evt  = (m_evt & ~(clr & ~m_rise)) | rs_v;
            m_rise = rs_v;
            m_fall = fl_v;
        end
        exp_q.push_back({m_lvl, m_rise, m_fall, m_evt, |m_evt});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [CH-1:0] r, input logic [CH-1:0] clr, input logic rs);
        raw     = r;
        evt_clr = clr;
        rst     = rs;
        model_edge(r, clr, rs);
        @(posedge clk);
        #2;
    endtask

    task automatic hold_raw(input logic [CH-1:0] r, input int n);
        repeat (n) drive(r, '0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b exp=%b", name, mon_cycle, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mon_cycle++;
            chk("level", level, e[W-1 -: CH]);
            chk("rise",  rise,  e[W-1-CH -: CH]);
            chk("fall",  fall,  e[W-1-2*CH -: CH]);
            chk("evt",   evt,   e[W-1-3*CH -: CH]);
            chk("irq",   {{(CH-1){1'b0}}, irq}, {{(CH-1){1'b0}}, e[0]});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int            rem [CH];
        logic [CH-1:0] rv;
        logic [CH-1:0] clr;
        logic          rs;

        // Reset for three cycles with idle pads.
        repeat (3) drive(4'b1111, '0, 1'b1);
        hold_raw(4'b1111, 3);

        // Clean press on channel 1.
        hold_raw(4'b1101, 20);
        // Bounce on channel 2 shorter than the window.
        hold_raw(4'b1001, 5);
        hold_raw(4'b1101, 15);
        // Release channel 1, then clear its sticky flag.
        hold_raw(4'b1111, 15);
        drive(4'b1111, 4'b0010, 1'b0);
        hold_raw(4'b1111, 4);

        // Clear on channel 0 in the cycle its rise pulse is visible.
        hold_raw(4'b1110, 11);
        drive(4'b1110, 4'b0001, 1'b0);
        hold_raw(4'b1110, 3);

        // Channel 3 pressed, reset during its check, held through reset.
        hold_raw(4'b0110, 5);
        drive(4'b0110, '0, 1'b1);
        hold_raw(4'b0110, 45);
        hold_raw(4'b1111, 15);
        drive(4'b1111, 4'b1111, 1'b0);
        hold_raw(4'b1111, 3);

        // Randomized activity with mixed short bounces and long holds.
        rv = 4'b1111;
        for (int c = 0; c < CH; c++) rem[c] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (rem[c] == 0) begin
                    rv[c]  = 1'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(9, 40) : $urandom_range(1, 12);
                end
                rem[c] = rem[c] - 1;
            end
            clr = ($urandom_range(0, 3) == 0) ? CH'($urandom_range(0, 15)) : '0;
            rs  = ($urandom_range(0, 399) == 0);
            drive(rv, clr, rs);
        end
        hold_raw(4'b1111, 15);

        // Drain remaining expectations with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_key_debounce.md
# io_key_debounce

Parametrised multi-channel input conditioner for the board push-buttons (KEY) and slide switches (SW) feeding the RV32I memory-mapped input peripheral. Each channel gets a synchroniser, a per-channel debounce state machine, single-cycle rise and fall pulses, and a sticky event flag with write-1-to-clear. A summary interrupt is also provided. It replaces the raw, unsynchronised sampling of KEY/SW at the I/O bus and generalises it to any channel count, polarity and debounce window.

## Interface
- CH, 4, number of independent input channels (≥1)
- SYNC_STAGES, 2, synchroniser flop depth (≥2)
- STABLE_CYCLES, 50000, consecutive stable cycles required to accept a new level (≥1; 1 ms at 50 MHz)
- ACTIVE_LOW, 1, 1 = raw input is pressed when 0 (KEY); 0 = pressed when 1 (SW)
- REPEAT_DELAY, 25000000, hold time before first auto-repeat (used only with IO_KEY_REPEAT_EN)
- REPEAT_PERIOD, 5000000, auto-repeat interval (used only with IO_KEY_REPEAT_EN)

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge
- i_rst  in  1  synchronous reset, active-high
- i_raw  in  CH  asynchronous raw pad inputs
- i_evt_clr  in  CH  write-1-to-clear strobe for o_evt, one bit per channel
- o_level  out  CH  debounced logical level; 1 = pressed/on, already polarity-corrected
- o_rise  out  CH  one-cycle pulse on accepted press, plus auto-repeat pulses when enabled
- o_fall  out  CH  one-cycle pulse on accepted release
- o_evt  out  CH  sticky press flag
- o_irq  out  1  OR of all o_evt bits

## Operation
- Synchroniser: an SYNC_STAGES-deep flop chain per channel. Polarity is corrected after the last stage: s = sync ^ ACTIVE_LOW.
- Per-channel FSM with states REL, CHK_P, PRS and CHK_R. The counter is localparam-sized CNT_W = $clog2(STABLE_CYCLES+1).
  - REL: if s=1, go to CHK_P with cnt=1. Otherwise stay.
  - CHK_P: if s=0, go to REL with cnt=0 (bounce rejected, no output). If s=1 and cnt==STABLE_CYCLES, go to PRS, set o_level=1 and pulse o_rise. Otherwise cnt++.
  - PRS and CHK_R mirror REL and CHK_P with s inverted. Acceptance in CHK_R clears o_level and pulses o_fall.
  - With STABLE_CYCLES=1, acceptance occurs on the first cycle in the CHK state.
- Counter saturates at STABLE_CYCLES and never wraps.
- o_evt[i]: set on o_rise[i] and cleared on i_evt_clr[i]. When both happen in the same cycle, set wins, so no press is lost. A clear on a bit that is already 0 is harmless.
- o_irq is combinational OR of o_evt. All other outputs are registered.
- Channels are fully independent. Simultaneous transitions on multiple channels each produce their own pulses in the same cycle.

## Timing
- Reset (i_rst=1 at an edge):
  - sync flops load the idle raw value (ACTIVE_LOW ? 1 : 0)
  - FSM = REL and cnt = 0
  - o_level, o_rise, o_fall and o_evt = 0, so o_irq = 0
- Reset asserted mid-CHK abandons the check. No pulse is emitted in the reset cycle or the cycle after.
- Latency: a raw change held stable is first sampled at edge E. o_level updates and the pulse is visible after edge E+SYNC_STAGES+STABLE_CYCLES.
- Pulses are exactly one cycle wide.
- Bounce rule: any return of s to the old level before acceptance restarts the full window.
- Inputs held at a constant pressed level through reset are accepted one latency period after reset deassertion. They produce o_rise.

## Configuration
- Macro: IO_KEY_REPEAT_EN
- Defined:
  - In PRS, a per-channel hold counter runs from acceptance.
  - The first extra o_rise pulse comes REPEAT_DELAY cycles after acceptance. Further pulses follow every REPEAT_PERIOD cycles while in PRS.
  - Each repeat pulse also sets o_evt.
  - Leaving PRS (entering CHK_R) stops the hold counter and resets it to 0.
- Not defined: no hold counter is built, REPEAT_* parameters are ignored, and exactly one o_rise pulse occurs per press.

## Test plan
Bench configuration: CH=4, SYNC_STAGES=2, STABLE_CYCLES=8, ACTIVE_LOW=1, idle i_raw=4'b1111.

1. Reset: i_rst=1 for 3 cycles -> all outputs 0, including o_irq=0.
2. Press: i_raw[1]=0 first sampled at edge E -> after edge E+10, o_level=4'b0010, o_rise=4'b0010 for 1 cycle, o_evt[1]=1 and o_irq=1.
3. Bounce: i_raw[2]=0 for 5 cycles, then 1 -> o_level[2], o_rise[2] and o_evt[2] stay 0 throughout.
4. Release and clear:
   - i_raw[1]=1 -> o_fall[1] pulses 10 cycles later and o_evt[1] stays 1.
   - i_evt_clr=4'b0010 -> o_evt[1]=0 next cycle and o_irq=0.
5. Clear/set collision: i_evt_clr[0]=1 in the same cycle o_rise[0] pulses -> o_evt[0]=1 afterwards. Reset asserted during CHK_P of channel 3 -> no pulse on channel 3.
6. Auto-repeat with IO_KEY_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5: hold i_raw[0]=0 -> o_rise[0] at acceptance+0, +20, +25 and +30. Without the macro, only the +0 pulse occurs.
